tlul_mem_responder: RTL and testbench

TLUL_MEM_RESPONDER -- requirements
Module: tlul_mem_responder
Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning channel A address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width; MASK_WIDTH=DATA_WIDTH/8 derived.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning number of DATA_WIDTH words of storage.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 a_valid  input  1  channel A request valid.
REQ-007 a_ready  output  1  responder can accept channel A this cycle.
REQ-008 a_opcode  input  OPCODE_WIDTH  Get=4, PutFullData=0, PutPartialData=1.
REQ-009 a_param  input  PARAM_WIDTH  ignored.
REQ-010 a_size  input  SIZE_WIDTH  log2 bytes of access.
REQ-011 a_source  input  1  requester ID, echoed on d_source.
REQ-012 a_address  input  ADDR_WIDTH  byte address.
REQ-013 a_mask  input  MASK_WIDTH  byte-lane write enables.
REQ-014 a_data  input  DATA_WIDTH  write data.
REQ-015 d_valid  output  1  response valid.
REQ-016 d_ready  input  1  requester accepts response.
REQ-017 d_opcode  output  OPCODE_WIDTH  AccessAck=0 for Puts, AccessAckData=1 for Get.
REQ-018 d_param  output  PARAM_WIDTH  constant 0.
REQ-019 d_size  output  SIZE_WIDTH  echo of accepted a_size.
REQ-020 d_source  output  1  echo of accepted a_source.
REQ-021 d_sink  output  1  constant 0.
REQ-022 d_data  output  DATA_WIDTH  read word for Get, 0 for Put or error.
REQ-023 d_error  output  1  request was rejected.
Function
REQ-024 a_ready SHALL equal (!d_valid || d_ready), combinationally; request accepted when a_valid && a_ready.
REQ-025 Accept in cycle N SHALL drive d_valid=1 with the matching response in cycle N+1 (latency 1); zero-bubble back-to-back throughput when d_ready held high.
REQ-026 While d_valid && !d_ready, all d_* outputs SHALL hold stable and no request SHALL be accepted.
REQ-027 d_valid handshake and new accept in the same cycle SHALL keep d_valid=1 and load the new response; handshake without accept SHALL clear d_valid next cycle.
REQ-028 Word index = a_address[log2(DEPTH)+log2(MASK_WIDTH)-1 : log2(MASK_WIDTH)]; Get returns full word, lanes unaffected by a_size.
REQ-029 Put SHALL write only byte lanes with a_mask bit set, committed in the accept cycle; a Get accepted the next cycle SHALL return the new data.
REQ-030 Two-state FSM (IDLE: d_valid=0; RESP: d_valid=1) SHALL follow REQ-024..027; no other states.
REQ-031 Error (with checks compiled in): unsupported opcode, a_size > log2(MASK_WIDTH), address not aligned to 2^a_size, or word index >= DEPTH -> no write, d_error=1, d_data=0, d_opcode per requested opcode class (Get->1, else 0).
Reset
REQ-032 Reset SHALL force d_valid=0, d_opcode/d_param/d_size/d_source/d_sink/d_data/d_error=0, FSM=IDLE; storage contents SHALL NOT be reset.
REQ-033 Reset asserted with d_valid=1 SHALL drop the pending response; a_ready=1 in the first cycle after reset deasserts.
Configuration
REQ-034 Macro TLUL_MEM_RESPONDER_ERR_CHECK_EN defined: REQ-031 checks active.
REQ-035 Macro undefined: all requests legal, unknown opcodes treated as Get, out-of-range index wraps modulo DEPTH, d_error tied 0.
Structure
REQ-036 Package tlul_pkg SHALL hold opcode constants (GET, PUT_FULL, PUT_PARTIAL, ACCESS_ACK, ACCESS_ACK_DATA) and SIZE/OPCODE/PARAM widths (3).
REQ-037 Storage SHALL be sub-module tlul_mem_array (byte-enable write, synchronous read, DEPTH x DATA_WIDTH).
Verification
REQ-038 PutFull addr 0x10, data 0xDEADBEEF, mask 0xF; Get 0x10 -> AccessAck then AccessAckData 0xDEADBEEF, d_error=0, 1-cycle latency each.
REQ-039 PutPartial addr 0x10, data 0x000000AA, mask 0x1 after REQ-038 -> Get returns 0xDEADBEAA.
REQ-040 d_ready=0 for 5 cycles after a Get -> d_* stable, a_ready=0; d_ready=1 -> single handshake, then a_ready=1.
REQ-041 Four back-to-back Gets, d_ready=1 throughout, source alternating 0/1 -> four consecutive d_valid cycles, d_source 0,1,0,1.
REQ-042 With ERR_CHECK_EN: Get addr 0x2 size 2 -> d_error=1, d_data=0; Put addr DEPTH*4 -> d_error=1, memory unchanged; reset during stalled response -> d_valid=0 next cycle.

---
 rtl/tlul_pkg.sv | 22 ++
 rtl/tlul_mem_array.sv | 32 +++
 rtl/tlul_mem_responder.sv | 118 +++++++++++
 tb/tb_tlul_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL opcode constants, channel field widths and the registered response record.
package tlul_pkg;

    localparam int SIZE_WIDTH   = 3;
    localparam int OPCODE_WIDTH = 3;
    localparam int PARAM_WIDTH  = 3;

    localparam logic [OPCODE_WIDTH-1:0] GET             = 3'd4;
    localparam logic [OPCODE_WIDTH-1:0] PUT_FULL        = 3'd0;
    localparam logic [OPCODE_WIDTH-1:0] PUT_PARTIAL     = 3'd1;
    localparam logic [OPCODE_WIDTH-1:0] ACCESS_ACK      = 3'd0;
    localparam logic [OPCODE_WIDTH-1:0] ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [SIZE_WIDTH-1:0]   size;
        logic                    source;
        logic                    error;
        logic                    rd;
    } rsp_t;

endpackage

// File: rtl/tlul_mem_array.sv
// tlul_mem_array: DEPTH x DATA_WIDTH storage with byte-enable write and registered read.
module tlul_mem_array
    import tlul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int MASK_WIDTH = DATA_WIDTH / 8,
    localparam int IDXW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [IDXW-1:0]       i_addr,
    input  logic [MASK_WIDTH-1:0] i_be,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read data only moves on a read so a stalled response keeps its word.
    always_ff @(posedge clk) begin
        if (i_we)
            for (int b = 0; b < MASK_WIDTH; b++)
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tlul_mem_responder.sv
// tlul_mem_responder: single-beat TL-UL memory responder, 1-cycle response latency.
// Define TLUL_MEM_RESPONDER_ERR_CHECK_EN to reject bad opcode/size/alignment/range requests.
module tlul_mem_responder
    import tlul_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic                    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic                    d_source,
    output logic                    d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error
);

    localparam int OFFW = $clog2(MASK_WIDTH);
    localparam int IDXW = $clog2(DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [0:0]            r_state;
    rsp_t                  r_rsp;
    rsp_t                  w_rsp;
    logic                  w_accept;
    logic                  w_is_get;
    logic                  w_is_put;
    logic                  w_rd_class;
    logic                  w_err;
    logic [IDXW-1:0]       w_idx;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    assign w_is_get = a_opcode == GET;
    assign w_is_put = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
    assign w_idx    = a_address[IDXW+OFFW-1:OFFW];
    assign w_unused = ^{a_param, a_address};

`ifdef TLUL_MEM_RESPONDER_ERR_CHECK_EN
    logic w_bad_op;
    logic w_bad_size;
    logic w_misalign;
    logic w_oob;

    assign w_bad_op   = !(w_is_get || w_is_put);
    assign w_bad_size = a_size > SIZE_WIDTH'(OFFW);
    assign w_misalign = (a_address & ((ADDR_WIDTH'(1) << a_size) - ADDR_WIDTH'(1))) != '0;
    assign w_oob      = (a_address >> OFFW) >= ADDR_WIDTH'(DEPTH);
    assign w_err      = w_bad_op || w_bad_size || w_misalign || w_oob;
    assign w_rd_class = w_is_get;
`else
    // Without checks anything that is not a Put reads.
    assign w_err      = 1'b0;
    assign w_rd_class = !w_is_put;
`endif

    assign d_valid  = r_state == RESP;
    assign a_ready  = !d_valid || d_ready;
    assign w_accept = a_valid && a_ready;

    assign w_rsp = '{
        opcode: w_rd_class ? ACCESS_ACK_DATA : ACCESS_ACK,
        size:   a_size,
        source: a_source,
        error:  w_err,
        rd:     w_rd_class && !w_err
    };

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rsp   <= '0;
        end else if (w_accept) begin
            r_state <= RESP;
            r_rsp   <= w_rsp;
        end else if (d_ready) begin
            r_state <= IDLE;
        end
    end

    tlul_mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_accept && w_is_put && !w_err),
        .i_re   (w_accept && w_rsp.rd),
        .i_addr (w_idx),
        .i_be   (a_mask),
        .i_wdata(a_data),
        .o_rdata(w_rdata)
    );

    assign d_opcode = r_rsp.opcode;
    assign d_param  = '0;
    assign d_size   = r_rsp.size;
    assign d_source = r_rsp.source;
    assign d_sink   = 1'b0;
    assign d_error  = r_rsp.error;
    assign d_data   = r_rsp.rd ? w_rdata : '0;

endmodule

// File: tb/tb_tlul_mem_responder.sv
// tb_tlul_mem_responder: table-driven transactions plus stall, back-to-back, reset and error/wrap sequences.
module tb_tlul_mem_responder;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic        a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic        d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tlul_mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_opcode (a_opcode),
        .a_param  (a_param),
        .a_size   (a_size),
        .a_source (a_source),
        .a_address(a_address),
        .a_mask   (a_mask),
        .a_data   (a_data),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_opcode (d_opcode),
        .d_param  (d_param),
        .d_size   (d_size),
        .d_source (d_source),
        .d_sink   (d_sink),
        .d_data   (d_data),
        .d_error  (d_error)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic        src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [2:0]  e_op;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] size, input logic src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_valid   = 1'b1;
    endtask

    task automatic xact(input vec_t v);
        d_ready = 1'b1;
        drive(v.op, v.size, v.src, v.addr, v.mask, v.data);
        chk("a_ready", {31'd0, a_ready}, 32'd1);
        go();
        a_valid = 1'b0;
        chk("d_valid", {31'd0, d_valid}, 32'd1);
        chk("d_opcode", {29'd0, d_opcode}, {29'd0, v.e_op});
        chk("d_data", d_data, v.e_data);
        chk("d_error", {31'd0, d_error}, {31'd0, v.e_err});
        chk("d_source", {31'd0, d_source}, {31'd0, v.src});
        chk("d_size", {29'd0, d_size}, {29'd0, v.size});
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] size, input logic src,
                                input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                                input logic [2:0] e_op, input logic [31:0] e_data, input logic e_err);
        mk = '{op, size, src, addr, mask, data, e_op, e_data, e_err};
    endfunction

    vec_t tbl [12];
    logic [31:0] held;

    initial begin
        tbl[0]  = mk(PUT_FULL,    3'd2, 1'b0, 32'h10,  4'hF, 32'hDEADBEEF, ACCESS_ACK,      32'h0,        1'b0);
        tbl[1]  = mk(GET,         3'd2, 1'b1, 32'h10,  4'hF, 32'h0,        ACCESS_ACK_DATA, 32'hDEADBEEF, 1'b0);
        tbl[2]  = mk(PUT_PARTIAL, 3'd0, 1'b0, 32'h10,  4'h1, 32'h000000AA, ACCESS_ACK,      32'h0,        1'b0);
        tbl[3]  = mk(GET,         3'd2, 1'b0, 32'h10,  4'hF, 32'h0,        ACCESS_ACK_DATA, 32'hDEADBEAA, 1'b0);
        tbl[4]  = mk(PUT_FULL,    3'd2, 1'b1, 32'h20,  4'hF, 32'h11223344, ACCESS_ACK,      32'h0,        1'b0);
        tbl[5]  = mk(PUT_PARTIAL, 3'd2, 1'b0, 32'h20,  4'hA, 32'hAABBCCDD, ACCESS_ACK,      32'h0,        1'b0);
        tbl[6]  = mk(GET,         3'd2, 1'b1, 32'h20,  4'hF, 32'h0,        ACCESS_ACK_DATA, 32'hAA22CC44, 1'b0);
        tbl[7]  = mk(GET,         3'd1, 1'b0, 32'h22,  4'hC, 32'h0,        ACCESS_ACK_DATA, 32'hAA22CC44, 1'b0);
        tbl[8]  = mk(PUT_FULL,    3'd2, 1'b1, 32'h10,  4'h0, 32'h0,        ACCESS_ACK,      32'h0,        1'b0);
        tbl[9]  = mk(GET,         3'd2, 1'b0, 32'h10,  4'hF, 32'h0,        ACCESS_ACK_DATA, 32'hDEADBEAA, 1'b0);
        tbl[10] = mk(PUT_FULL,    3'd2, 1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D, ACCESS_ACK,      32'h0,        1'b0);
        tbl[11] = mk(GET,         3'd2, 1'b0, 32'hFFC, 4'hF, 32'h0,        ACCESS_ACK_DATA, 32'hCAFEF00D, 1'b0);

        reset = 1'b1;
        a_valid = 1'b0;
        a_param = 3'd0;
        d_ready = 1'b0;
        drive(GET, 3'd2, 1'b0, 32'h0, 4'hF, 32'h0);
        a_valid = 1'b0;
        go();
        go();
        chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_d_opcode", {29'd0, d_opcode}, 32'd0);
        chk("rst_d_data", d_data, 32'd0);
        chk("rst_d_err_src_size", {27'd0, d_error, d_source, d_size}, 32'd0);
        chk("rst_d_param_sink", {28'd0, d_param, d_sink}, 32'd0);
        reset = 1'b0;
        go();
        chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);

        for (int i = 0; i < 12; i++) xact(tbl[i]);
        go();
        chk("idle_after_table", {31'd0, d_valid}, 32'd0);

        d_ready = 1'b0;
        drive(GET, 3'd2, 1'b1, 32'h10, 4'hF, 32'h0);
        go();
        drive(PUT_FULL, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_a_ready", {31'd0, a_ready}, 32'd0);
            chk("stall_d_valid", {31'd0, d_valid}, 32'd1);
            chk("stall_d_data", d_data, 32'hDEADBEAA);
            chk("stall_d_src_op", {28'd0, d_source, d_opcode}, {28'd0, 1'b1, ACCESS_ACK_DATA});
            go();
        end
        a_valid = 1'b0;
        d_ready = 1'b1;
        go();
        chk("release_d_valid", {31'd0, d_valid}, 32'd0);
        chk("release_a_ready", {31'd0, a_ready}, 32'd1);
        xact(mk(GET, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0, ACCESS_ACK_DATA, 32'hDEADBEAA, 1'b0));

        for (int i = 0; i < 4; i++) begin
            drive(GET, 3'd2, i[0], 32'h20, 4'hF, 32'h0);
            go();
            chk("b2b_d_valid", {31'd0, d_valid}, 32'd1);
            chk("b2b_d_source", {31'd0, d_source}, {31'd0, i[0]});
            chk("b2b_d_data", d_data, 32'hAA22CC44);
        end
        a_valid = 1'b0;
        go();
        chk("b2b_drain", {31'd0, d_valid}, 32'd0);

        d_ready = 1'b0;
        drive(GET, 3'd2, 1'b1, 32'h20, 4'hF, 32'h0);
        go();
        a_valid = 1'b0;
        chk("pre_rst_d_valid", {31'd0, d_valid}, 32'd1);
        reset = 1'b1;
        go();
        chk("rst_stall_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_stall_d_data", d_data, 32'd0);
        reset = 1'b0;
        go();
        chk("rst_stall_a_ready", {31'd0, a_ready}, 32'd1);

        xact(mk(PUT_FULL, 3'd2, 1'b0, 32'h0, 4'hF, 32'h01020304, ACCESS_ACK, 32'h0, 1'b0));
`ifdef TLUL_MEM_RESPONDER_ERR_CHECK_EN
        xact(mk(GET,      3'd2, 1'b1, 32'h2,    4'hF, 32'h0,        ACCESS_ACK_DATA, 32'h0, 1'b1));
        xact(mk(PUT_FULL, 3'd2, 1'b0, 32'h1000, 4'hF, 32'h55AA55AA, ACCESS_ACK,      32'h0, 1'b1));
        xact(mk(GET,      3'd3, 1'b0, 32'h0,    4'hF, 32'h0,        ACCESS_ACK_DATA, 32'h0, 1'b1));
        xact(mk(3'd7,     3'd2, 1'b1, 32'h0,    4'hF, 32'h0,        ACCESS_ACK,      32'h0, 1'b1));
        held = 32'h01020304;
`else
        xact(mk(PUT_FULL, 3'd2, 1'b0, 32'h1000, 4'hF, 32'h55AA55AA, ACCESS_ACK,      32'h0,        1'b0));
        xact(mk(3'd7,     3'd2, 1'b1, 32'h0,    4'hF, 32'h0,        ACCESS_ACK_DATA, 32'h55AA55AA, 1'b0));
        held = 32'h55AA55AA;
`endif
        xact(mk(GET, 3'd2, 1'b0, 32'h0, 4'hF, 32'h0, ACCESS_ACK_DATA, held, 1'b0));
        go();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
